// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: word width, nop and reset constants,
// FSM state encoding, skid-buffer entry layout and the PC increment helper.
// The decoder uses the same NOP_WORD constant.
package instruction_fetch_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_WORD = 16'h0800;
  localparam word_t RESET_PC = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t word;
    word_t pc;
  } fetch_entry_t;

  // PC+1, wrapping modulo 2^16.
  function automatic word_t pc_inc(input word_t p);
    return p + word_t'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port.
//   mem_req   : level read request (fetch -> memory)
//   mem_addr  : word address, valid while mem_req is high
//   mem_ready : mem_rdata valid this cycle (memory -> fetch)
//   mem_rdata : fetched word
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  mem_req;
  word_t mem_addr;
  logic  mem_ready;
  word_t mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word and its PC+1.
//   clk, rst : clock, synchronous active-low reset
//   load     : capture din, entry becomes full
//   unload   : entry consumed, becomes empty
//   clear    : discard entry (highest priority after reset)
//   dout     : stored entry
//   full     : entry occupied
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
    end else if (load && !clear) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage feeding the decoder.
//   clk, rst     : clock, synchronous active-low reset
//   stall        : hazard unit holds the fetch/decode boundary
//   redirect     : taken jump/branch; flush and reload PC from redirect_pc
//   mem          : instruction memory read port (master side)
//   instruction  : registered word to the decoder (NOP_WORD when empty)
//   if_pc        : PC+1 of instruction
//   valid        : instruction is a real fetched word
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter word_t RESET_PC_P = RESET_PC,
  parameter word_t NOP_WORD_P = NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  word_t                 redirect_pc,
  instruction_fetch_if.master   mem,
  output word_t                 instruction,
  output word_t                 if_pc,
  output logic                  valid
);

  fetch_state_t state;
  word_t        pc;
  logic         req_q;
  logic         xfer;
  logic         buf_load;
  logic         buf_unload;
  logic         buf_full;
  fetch_entry_t buf_in;
  fetch_entry_t buf_out;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc;

  always_comb begin
    xfer       = req_q && mem.mem_ready;
    buf_in     = '{word: mem.mem_rdata, pc: pc_inc(pc)};
    buf_load   = rst && !redirect && (state == ST_RUN) && xfer && stall;
    buf_unload = rst && !redirect && (state == ST_FULL) && !stall;
  end

  fetch_skid_buffer u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .unload (buf_unload),
    .clear  (redirect),
    .din    (buf_in),
    .dout   (buf_out),
    .full   (buf_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC_P;
      req_q       <= 1'b0;
      instruction <= NOP_WORD_P;
      if_pc       <= RESET_PC_P;
      valid       <= 1'b0;
    end else if (redirect) begin
      // Any same-edge transfer is dropped; the buffer clears itself.
      state       <= ST_RUN;
      pc          <= redirect_pc;
      req_q       <= 1'b1;
      instruction <= NOP_WORD_P;
      if_pc       <= redirect_pc;
      valid       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (xfer) begin
            pc <= pc_inc(pc);
            if (!stall) begin
              instruction <= mem.mem_rdata;
              if_pc       <= pc_inc(pc);
              valid       <= 1'b1;
              req_q       <= 1'b1;
            end else begin
              state <= ST_FULL;
              req_q <= 1'b0;
            end
          end else begin
            req_q <= 1'b1;
            if (!stall) begin
              instruction <= NOP_WORD_P;
              valid       <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (!stall) begin
            instruction <= buf_full ? buf_out.word : NOP_WORD_P;
            if_pc       <= buf_full ? buf_out.pc : if_pc;
            valid       <= buf_full;
            state       <= ST_RUN;
            req_q       <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t instruction;
  word_t if_pc;
  logic  valid;

  instruction_fetch_if mif ();

  // Side-effect-free memory: mem[i] = 16'h4000 + i.
  assign mif.mem_rdata = 16'h4000 + mif.mem_addr;

  instruction_fetch #(
    .RESET_PC_P (16'h0000),
    .NOP_WORD_P (16'h0800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (mif.master),
    .instruction (instruction),
    .if_pc       (if_pc),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fetch_entry_t sb[$];
  word_t        exp_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, predict from the pre-edge handshake,
  // then check the registered outputs just after the edge.
  task automatic cyc(input logic r, input logic st, input logic rd,
                     input logic rdy, input word_t rpc);
    logic         xfer;
    word_t        p_instr, p_ifpc;
    logic         p_valid;
    fetch_entry_t e;
    rst = r; stall = st; redirect = rd; redirect_pc = rpc; mif.mem_ready = rdy;
    #1;
    xfer    = mif.mem_req && rdy;
    p_instr = instruction;
    p_ifpc  = if_pc;
    p_valid = valid;
    if (mif.mem_req && r) check_eq("mem_addr", mif.mem_addr, exp_pc);
    @(posedge clk);
    #1;
    if (!r) begin
      sb.delete();
      exp_pc = 16'h0000;
      check_eq("rst_instr", instruction, 16'h0800);
      check_eq("rst_if_pc", if_pc, 16'h0000);
      check_eq("rst_valid", valid, 1'b0);
      check_eq("rst_req", mif.mem_req, 1'b0);
    end else if (rd) begin
      sb.delete();
      exp_pc = rpc;
      check_eq("redir_instr", instruction, 16'h0800);
      check_eq("redir_valid", valid, 1'b0);
      check_eq("redir_if_pc", if_pc, rpc);
    end else begin
      if (xfer) begin
        sb.push_back('{word: 16'h4000 + exp_pc, pc: exp_pc + 16'h0001});
        exp_pc = exp_pc + 16'h0001;
      end
      if (st) begin
        check_eq("hold_instr", instruction, p_instr);
        check_eq("hold_if_pc", if_pc, p_ifpc);
        check_eq("hold_valid", valid, p_valid);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("deliv_valid", valid, 1'b1);
        check_eq("deliv_instr", instruction, e.word);
        check_eq("deliv_if_pc", if_pc, e.pc);
      end else begin
        check_eq("bubble_valid", valid, 1'b0);
        check_eq("bubble_instr", instruction, 16'h0800);
      end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mif.mem_ready = 1'b1;
    exp_pc = 16'h0000;

    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // First cycle out of reset: bubble, request rises.
    cyc(1, 0, 0, 1, 0);
    check_eq("req_after_rst", mif.mem_req, 1'b1);
    check_eq("addr_after_rst", mif.mem_addr, 16'h0000);
    cyc(1, 0, 0, 1, 0);
    check_eq("first_instr", instruction, 16'h4000);
    check_eq("first_if_pc", if_pc, 16'h0001);

    // Stream up to pc=5.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mif.mem_addr == 16'h0005) begin
        found = 1'b1;
        break;
      end
      cyc(1, 0, 0, 1, 0);
    end
    check_eq("reach_pc5", found, 1'b1);

    // Stall for 3 cycles: word 5 is buffered, request drops.
    cyc(1, 1, 0, 1, 0);
    check_eq("stall_req_drop", mif.mem_req, 1'b0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    check_eq("stall_req_low", mif.mem_req, 1'b0);
    cyc(1, 0, 0, 1, 0);
    check_eq("unstall_instr", instruction, 16'h4005);
    check_eq("unstall_if_pc", if_pc, 16'h0006);
    check_eq("unstall_req", mif.mem_req, 1'b1);
    check_eq("unstall_addr", mif.mem_addr, 16'h0006);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // Redirect coinciding with a transfer.
    cyc(1, 0, 1, 1, 16'h0100);
    check_eq("redir_addr", mif.mem_addr, 16'h0100);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // Redirect while stalled in FULL.
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 16'h0200);
    check_eq("full_redir_req", mif.mem_req, 1'b1);
    check_eq("full_redir_addr", mif.mem_addr, 16'h0200);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // Memory busy for 2 cycles.
    cyc(1, 0, 0, 0, 0);
    check_eq("busy_addr1", mif.mem_addr, exp_pc);
    cyc(1, 0, 0, 0, 0);
    check_eq("busy_addr2", mif.mem_addr, exp_pc);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // PC wrap at 16'hFFFF.
    cyc(1, 0, 1, 1, 16'hFFFF);
    cyc(1, 0, 0, 1, 0);
    check_eq("wrap_if_pc", if_pc, 16'h0000);
    check_eq("wrap_addr", mif.mem_addr, 16'h0000);
    cyc(1, 0, 0, 1, 0);

    // Reset while a request is outstanding.
    cyc(1, 0, 0, 0, 0);
    check_eq("pre_rst_req", mif.mem_req, 1'b1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    check_eq("post_rst_instr", instruction, 16'h4000);

    check_eq("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage, directly upstream of the instruction decoder. Holds the program counter and issues level-sensitive read requests to the instruction memory port. Registers each returned word, with its PC+1, as the decoder's `instruction` input. A one-entry skid buffer absorbs hazard stalls, and a redirect input from jump resolution flushes the stage with a nop.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_WORD`, 16'h0800: instruction word driven while empty or flushed.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hazard unit holds the fetch/decode boundary.
- `redirect`  in  1  jump/branch taken; flush and reload PC.
- `redirect_pc`  in  16  target PC; valid when `redirect` is high.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  16  read address (word address).
- `mem_ready`  in  1  memory has `mem_rdata` valid this cycle.
- `mem_rdata`  in  16  fetched word.
- `instruction`  out  16  word to the decoder.
- `if_pc`  out  16  PC+1 of `instruction`, used for branch targets and mfpc.
- `valid`  out  1  `instruction` is a real fetched word, not a bubble.

## Operation
- Transfer: at a rising edge where `mem_req` and `mem_ready` are both high.
- Request rules:
  - `mem_req` is a level signal and the memory has no side effects.
  - `mem_addr` equals `pc` while `mem_req` is high.
  - `mem_addr` changes only on transfer or redirect.
- States:
  - RUN: requesting. `mem_req` = 1.
  - FULL: skid buffer occupied. `mem_req` = 0.
- Edge priority, highest first:
  1. `!rst`: pc=RESET_PC; instruction=NOP_WORD; if_pc=RESET_PC; valid=0; buffer empty; state RUN. `mem_req` is 0 during the reset cycle and 1 from the first cycle after it.
  2. `redirect`:
     - pc=redirect_pc; instruction=NOP_WORD; valid=0; if_pc=redirect_pc.
     - Buffer cleared; any same-edge transfer discarded; state RUN.
     - Redirect wins over `stall`.
  3. Transfer with `!stall` and buffer empty: instruction=mem_rdata; if_pc=pc+1; valid=1; pc=pc+1; stay RUN.
  4. Transfer with `stall`: buffer=mem_rdata plus pc+1; pc=pc+1; outputs hold; go FULL.
  5. FULL with `!stall`: output takes the buffer contents; valid=1; buffer empty; go RUN.
  6. `!stall`, no transfer, buffer empty: instruction=NOP_WORD; valid=0. A bubble is inserted while memory is busy.
  7. `stall`, no transfer: all outputs hold.
- Arithmetic: pc+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Stall never drops a fetched word, and no word is ever delivered twice.

## Timing
- Memory-ready to decoder latency: 1 cycle, since `instruction` is registered.
- Back-to-back transfers every cycle while `mem_ready` = 1 and `stall` = 0.
- Redirect:
  - Asserted in cycle n; `mem_addr`=redirect_pc in cycle n+1.
  - Target instruction is at the decoder in cycle n+2 at the earliest.
- FULL exit:
  - `stall` falls in cycle n; buffered word is at the decoder after edge n.
  - The request resumes in cycle n+1.
- Simultaneous `stall` fall and transfer while FULL is impossible, because `mem_req` is 0 in FULL.
- Reset mid-request: the outstanding request is abandoned. The memory must tolerate `mem_req` dropping without `mem_ready`.

## Structure
- Shared package / `globalDefines.v`: NOP_WORD (16'h0800), RESET_PC, 16-bit word width, FSM state encodings.
  - The decoder uses the same nop constant.
- Sub-module `fetch_skid_buffer`: one entry holding word plus PC, with load/unload/clear inputs and a `full` flag.
- The PC, the FSM and the output register live in the top module.

## Test plan
- Reset then free-running memory (`mem_ready`=1, memory[i]=16'h4000+i): `mem_addr` runs 0,1,2,…; instruction 16'h4000 appears one cycle after the first transfer; if_pc=1; valid=1.
- `stall` high for 3 cycles mid-stream at pc=5:
  - word 5 is buffered and `mem_req` drops;
  - after `stall` falls, instruction=mem[5] and if_pc=6;
  - `mem_addr`=6 next cycle;
  - no duplicate or missing words.
- `redirect`, redirect_pc=16'h0100, in the same cycle as a transfer: the fetched word is discarded; instruction=16'h0800; valid=0; next `mem_addr`=16'h0100.
- `redirect` during `stall` while FULL: buffer cleared; state RUN; `mem_addr`=redirect_pc next cycle.
- `mem_ready` low for 2 cycles: `mem_addr` held; two nop bubbles with valid=0; the fetch then resumes.
- pc=16'hFFFF transfer: if_pc=16'h0000; next `mem_addr`=16'h0000.
- Reset asserted mid-request: `mem_req`=0 and outputs at reset values on the following cycle.
